// File: rtl/jtcomsc_cpu_wait.sv
// Main-CPU clock-enable generator for Combat School: fractional divider plus wait
// scheduler that withholds enables on unconfirmed ROM reads or busy devices and repays them later.
module jtcomsc_cpu_wait #(
    parameter int NUM    = 1,
    parameter int DEN    = 8,
    parameter int MAXOWE = 15,
    parameter int AW     = 18
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rom_cs,
    input  logic [AW-1:0]                   rom_addr,
    input  logic                            rom_ok,
    input  logic                            dev_busy,
    output logic                            cpu_cen,
    output logic                            stall,
    output logic [$clog2(MAXOWE+1)-1:0]     owed,
    output logic                            lost
);
    localparam int ACCW = $clog2(2*DEN);
    localparam int OWW  = $clog2(MAXOWE+1);

    logic [ACCW-1:0] acc, sum, acc_next;
    logic            tick;
    logic [AW-1:0]   addr_q;
    logic            cs_q;
    logic            ok_valid, blocked;
    logic            cen_next, lost_next;
    logic [OWW-1:0]  owed_next;

    always_comb begin
        sum      = acc + ACCW'(NUM);
        tick     = sum >= ACCW'(DEN);
        acc_next = tick ? sum - ACCW'(DEN) : sum;
    end

    // rom_ok only counts once the same access has been seen for a full clock
    always_comb begin
        ok_valid = rom_cs & cs_q & (rom_addr == addr_q) & rom_ok;
        blocked  = (rom_cs & ~ok_valid) | dev_busy;
    end

    // A tick right after a recovery enable still issues, so cpu_cen may be high
    // on two consecutive clocks in that case; recoveries alone are never adjacent.
    always_comb begin
        cen_next  = 1'b0;
        lost_next = 1'b0;
        owed_next = owed;
        if (blocked) begin
            if (tick) begin
                if (owed < OWW'(MAXOWE)) owed_next = owed + OWW'(1);
                else                     lost_next = 1'b1;
            end
        end else if (tick) begin
            cen_next = 1'b1;
        end else if (owed != '0 && !cpu_cen) begin
            cen_next  = 1'b1;
            owed_next = owed - OWW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            cpu_cen <= 1'b0;
            stall   <= 1'b0;
            owed    <= '0;
            lost    <= 1'b0;
        end else begin
            acc     <= acc_next;
            addr_q  <= rom_addr;
            cs_q    <= rom_cs;
            cpu_cen <= cen_next;
            stall   <= blocked | (owed_next != '0);
            owed    <= owed_next;
            lost    <= lost_next;
        end
    end
endmodule

// File: tb/tb_jtcomsc_cpu_wait.sv
// Scoreboard bench for jtcomsc_cpu_wait: a cycle model pushes expected outputs,
// compared one clock later; directed counts cover cadence, recovery and saturation.
module tb_jtcomsc_cpu_wait;
    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rom_cs, rom_ok, dev_busy;
    logic [AW-1:0] rom_addr;
    logic          cpu_cen, stall, lost;
    logic [3:0]    owed;
    logic          f_cen, f_stall, f_lost;
    logic [3:0]    f_owed;

    jtcomsc_cpu_wait #(.NUM(1), .DEN(8), .MAXOWE(15), .AW(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_ok(rom_ok), .dev_busy(dev_busy), .cpu_cen(cpu_cen),
        .stall(stall), .owed(owed), .lost(lost)
    );

    jtcomsc_cpu_wait #(.NUM(3), .DEN(8), .MAXOWE(15), .AW(AW)) u_frac (
        .clk(clk), .rst_n(rst_n), .rom_cs(1'b0), .rom_addr('0),
        .rom_ok(1'b0), .dev_busy(1'b0), .cpu_cen(f_cen),
        .stall(f_stall), .owed(f_owed), .lost(f_lost)
    );

    typedef struct { int cen; int stall; int owed; int lost; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    int m_acc, m_cen, m_owed, m_addr, m_cs;
    int f_count, f_adj;
    logic f_prev;

    // Model the next clock from the currently driven inputs, then advance and compare
    task automatic step();
        exp_t e, g;
        int sum, tick, okv, blk;
        if (!rst_n) begin
            m_acc = 0; m_cen = 0; m_owed = 0; m_addr = 0; m_cs = 0;
            e = '{0, 0, 0, 0};
        end else begin
            sum  = m_acc + 1;
            tick = (sum >= 8);
            okv  = rom_cs && m_cs && (int'(rom_addr) == m_addr) && rom_ok;
            blk  = (rom_cs && !okv) || dev_busy;
            e.lost = 0;
            e.cen  = 0;
            if (blk) begin
                if (tick) begin
                    if (m_owed < 15) m_owed++;
                    else             e.lost = 1;
                end
            end else if (tick) begin
                e.cen = 1;
            end else if (m_owed > 0 && m_cen == 0) begin
                e.cen = 1;
                m_owed--;
            end
            e.stall = (blk || m_owed > 0);
            e.owed  = m_owed;
            m_acc   = tick ? sum - 8 : sum;
            m_addr  = int'(rom_addr);
            m_cs    = rom_cs;
            m_cen   = e.cen;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("sb_cen",   cpu_cen, g.cen);
        check("sb_stall", stall,   g.stall);
        check("sb_owed",  owed,    g.owed);
        check("sb_lost",  lost,    g.lost);
        if (f_cen) begin
            f_count++;
            if (f_prev) f_adj++;
        end
        f_prev = f_cen;
    endtask

    initial begin
        int n, first, last, gap_bad, bad, mask, rec, adj, prev_owed, r, prev_r;
        rst_n = 1'b0; rom_cs = 1'b0; rom_ok = 1'b0; dev_busy = 1'b0; rom_addr = '0;
        f_count = 0; f_adj = 0; f_prev = 1'b0;
        step();
        step();
        check("rst_cen", cpu_cen, 0);
        check("rst_owed", owed, 0);
        rst_n = 1'b1;

        // free run: ten pulses, eight apart, first after edge 8
        n = 0; first = -1; last = -1; gap_bad = 0; bad = 0;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (cpu_cen) begin
                n++;
                if (first < 0) first = i;
                else if (i - last != 8) gap_bad++;
                last = i;
            end
            if (stall || owed != 0) bad++;
        end
        check("free_count", n, 10);
        check("free_first", first, 8);
        check("free_gap", gap_bad, 0);
        check("free_stall", bad, 0);

        // ROM miss over two ticks, then confirm and watch repayment and cadence
        rom_cs = 1'b1; rom_addr = 18'h04000; rom_ok = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("miss_owed", owed, 2);
        check("miss_stall", stall, 1);
        rom_ok = 1'b1;
        mask = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (cpu_cen) mask |= (1 << i);
        end
        // recoveries at 1 and 3, tick right after recovery at 4, next tick at 12
        check("miss_pattern", mask, (1 << 1) | (1 << 3) | (1 << 4) | (1 << 12));
        check("miss_owed_end", owed, 0);
        check("miss_stall_end", stall, 0);

        // stale rom_ok: address changes on a tick clock
        for (int i = 0; i < 8 && m_acc != 7; i++) step();
        rom_addr = 18'h04001;
        step();
        check("stale_cen", cpu_cen, 0);
        check("stale_owed", owed, 1);
        step();
        check("stale_repay_cen", cpu_cen, 1);
        check("stale_repay_owed", owed, 0);

        // saturation
        rom_cs = 1'b0; rom_ok = 1'b0; dev_busy = 1'b1;
        n = 0;
        for (int i = 0; i < 160; i++) begin
            step();
            if (lost) n++;
        end
        check("sat_lost", n, 5);
        check("sat_owed", owed, 15);
        dev_busy = 1'b0;
        rec = 0; adj = 0; prev_owed = int'(owed); prev_r = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            r = (cpu_cen && int'(owed) < prev_owed);
            if (r) rec++;
            if (r && prev_r) adj++;
            prev_r = r;
            prev_owed = int'(owed);
        end
        check("sat_recoveries", rec, 15);
        check("sat_adjacent", adj, 0);
        check("sat_owed_end", owed, 0);

        // reset mid-recovery
        dev_busy = 1'b1;
        for (int i = 0; i < 32; i++) step();
        check("mid_owed", owed, 4);
        dev_busy = 1'b0;
        rst_n = 1'b0;
        step();
        check("mid_rst_cen", cpu_cen, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_owed", owed, 0);
        check("mid_rst_lost", lost, 0);
        rst_n = 1'b1;
        mask = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (cpu_cen) mask |= (1 << i);
        end
        check("mid_restart", mask, 1 << 8);

        // fractional 3/8 ratio on the second instance
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        f_count = 0; f_adj = 0; f_prev = 1'b0;
        for (int i = 0; i < 800; i++) step();
        check("frac_count", f_count, 300);
        check("frac_adjacent", f_adj, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
